// File: rtl/ballot_driver.sv
// ballot_driver: sequences mode/button presses into a voting machine and reports results.
// Ports: clock, reset (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_cand command in;
//   mode, button1..4 out to the machine; led in from it;
//   rsp_valid/rsp_op/rsp_count/rsp_match/rsp_err response out.
// Optional macro BALLOT_DRIVER_FLASH_CHECK_EN: flags votes that never flash led==8'hFF.
`timescale 1ns/1ps
module ballot_driver #(
  parameter int HOLD_CYCLES = 12,
  parameter int GAP_CYCLES  = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [1:0] cmd_cand,
  output logic       mode,
  output logic       button1,
  output logic       button2,
  output logic       button3,
  output logic       button4,
  input  logic [7:0] led,
  output logic       rsp_valid,
  output logic       rsp_op,
  output logic [7:0] rsp_count,
  output logic       rsp_match,
  output logic       rsp_err
);

  // Timing values below 11 are raised to 11.
  localparam int HOLD_EFF = (HOLD_CYCLES < 11) ? 11 : HOLD_CYCLES;
  localparam int GAP_EFF  = (GAP_CYCLES < 11) ? 11 : GAP_CYCLES;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_EFF - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_EFF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PRESS,
    S_GAP,
    S_RESP
  } state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_op;
  logic [1:0] r_cand;
  logic       r_mode;
  logic [3:0] r_btn;
  logic       r_ready;
  logic       r_rsp_valid;
  logic       r_rsp_op;
  logic [7:0] r_rsp_count;
  logic       r_rsp_match;
  logic [7:0] r_shadow [4];
  logic [3:0] w_onehot;
  logic       w_match;

  assign w_onehot = 4'b0001 << r_cand;
  assign w_match  = (led == r_shadow[r_cand]);

`ifdef BALLOT_DRIVER_FLASH_CHECK_EN
  logic r_seen;
  logic r_rsp_err;
  logic w_seen;

  // Flash seen so far, including the current cycle.
  assign w_seen  = r_seen | (led == 8'hFF);
  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= 1'b0;
      r_cand      <= '0;
      r_mode      <= 1'b0;
      r_btn       <= '0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_op    <= 1'b0;
      r_rsp_count <= '0;
      r_rsp_match <= 1'b0;
      for (int i = 0; i < 4; i++) r_shadow[i] <= '0;
`ifdef BALLOT_DRIVER_FLASH_CHECK_EN
      r_seen    <= 1'b0;
      r_rsp_err <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_cand  <= cmd_cand;
            r_mode  <= cmd_op;
            r_ready <= 1'b0;
            r_cnt   <= 8'd1;
            r_state <= S_SETUP;
`ifdef BALLOT_DRIVER_FLASH_CHECK_EN
            r_seen  <= 1'b0;
`endif
          end
        end
        S_SETUP: begin
          if (r_cnt == 8'd0) begin
            r_btn   <= w_onehot;
            r_cnt   <= HOLD_LAST;
            r_state <= S_PRESS;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_PRESS: begin
`ifdef BALLOT_DRIVER_FLASH_CHECK_EN
          r_seen <= w_seen;
`endif
          if (r_cnt == 8'd0) begin
            r_btn   <= '0;
            r_cnt   <= GAP_LAST;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_GAP: begin
`ifdef BALLOT_DRIVER_FLASH_CHECK_EN
          r_seen <= w_seen;
`endif
          if (r_cnt == 8'd0) begin
            // led is sampled here, on the last GAP cycle.
            r_rsp_valid <= 1'b1;
            r_rsp_op    <= r_op;
            r_rsp_count <= r_op ? led : 8'd0;
            r_rsp_match <= r_op ? w_match : 1'b1;
`ifdef BALLOT_DRIVER_FLASH_CHECK_EN
            r_rsp_err   <= ~r_op & ~w_seen;
`endif
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_RESP: begin
          if (!r_op) r_shadow[r_cand] <= r_shadow[r_cand] + 8'd1;
          r_mode  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_btn   <= '0;
          r_mode  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign mode      = r_mode;
  assign button1   = r_btn[0];
  assign button2   = r_btn[1];
  assign button3   = r_btn[2];
  assign button4   = r_btn[3];
  assign rsp_valid = r_rsp_valid;
  assign rsp_op    = r_rsp_op;
  assign rsp_count = r_rsp_count;
  assign rsp_match = r_rsp_match;

endmodule

// File: tb/tb_ballot_driver.sv
// tb_ballot_driver: scoreboard bench for ballot_driver with a voting machine model.
// Checks per-cycle buttons/mode/ready, response fields, latency, wrap and reset abort.
`timescale 1ns/1ps
module tb_ballot_driver;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [1:0] cmd_cand;
  logic       mode;
  logic       button1;
  logic       button2;
  logic       button3;
  logic       button4;
  logic [7:0] led;
  logic       rsp_valid;
  logic       rsp_op;
  logic [7:0] rsp_count;
  logic       rsp_match;
  logic       rsp_err;

  ballot_driver dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cand  (cmd_cand),
    .mode      (mode),
    .button1   (button1),
    .button2   (button2),
    .button3   (button3),
    .button4   (button4),
    .led       (led),
    .rsp_valid (rsp_valid),
    .rsp_op    (rsp_op),
    .rsp_count (rsp_count),
    .rsp_match (rsp_match),
    .rsp_err   (rsp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Voting machine model: a vote bumps the count and flashes 8'hFF
  // while the button is held; a read shows the count and keeps it.
  logic [3:0] btn_w;
  logic [3:0] vm_prev;
  logic [7:0] vm_led;
  logic [7:0] vm_cnt [4];
  logic       tie0;

  assign btn_w = {button4, button3, button2, button1};
  assign led   = tie0 ? 8'h00 : vm_led;

  always @(posedge clock) begin
    if (reset) begin
      vm_prev <= '0;
      vm_led  <= '0;
      for (int i = 0; i < 4; i++) vm_cnt[i] <= '0;
    end else begin
      vm_prev <= btn_w;
      if (|(btn_w & ~vm_prev)) begin
        for (int i = 0; i < 4; i++) begin
          if (btn_w[i] && !vm_prev[i]) begin
            if (!mode) begin
              vm_cnt[i] <= vm_cnt[i] + 8'd1;
              vm_led    <= 8'hFF;
            end else begin
              vm_led <= vm_cnt[i];
            end
          end
        end
      end else if (!mode && btn_w == 4'b0) begin
        vm_led <= 8'h00;
      end
    end
  end

  typedef struct {
    logic       op;
    logic [1:0] cand;
    logic [7:0] cnt;
    logic       match;
    logic       err;
    int         t;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] tally [4];
  logic [10:0] last;
  int  n_chk = 0;
  int  n_err = 0;
  bit  mon_en = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_cmd(input logic op, input logic [1:0] cand,
                        input bit keep);
    exp_t e;
    int   n;
    int   t;
    logic ve;
    @(posedge clock);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cand  = cand;
    n = 0;
    forever begin
      @(negedge clock);
      if (cmd_ready) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 0, 1);
        cmd_valid = 1'b0;
        return;
      end
    end
    t = cyc;
    @(posedge clock);
    #1;
`ifdef BALLOT_DRIVER_FLASH_CHECK_EN
    ve = tie0;
`else
    ve = 1'b0;
`endif
    e.op    = op;
    e.cand  = cand;
    e.t     = t;
    e.match = 1'b1;
    if (!op) begin
      e.cnt = 8'd0;
      e.err = ve;
      tally[cand] = tally[cand] + 8'd1;
    end else begin
      e.cnt = tally[cand];
      e.err = 1'b0;
    end
    sb.push_back(e);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() > 0) chk("idle_timeout", 0, 1);
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clock);
    #1;
    reset = 1'b1;
    sb.delete();
    for (int i = 0; i < 4; i++) tally[i] = '0;
    last = '0;
    repeat (cycles) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    exp_t       e;
    int         k;
    logic [3:0] exp_btn;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_cand  = 2'd0;
    tie0      = 1'b0;
    last      = '0;
    for (int i = 0; i < 4; i++) tally[i] = '0;

    fork
      forever begin
        @(negedge clock);
        if (mon_en && !reset) begin
          if (sb.size() > 0) begin
            e = sb[0];
            k = cyc - e.t;
            if (k < 27) begin
              exp_btn = (k >= 3 && k <= 14) ? (4'b0001 << e.cand) : 4'b0000;
              chk("buttons", {28'd0, btn_w}, {28'd0, exp_btn});
              chk("mode", mode, e.op);
              chk("busy_ready", cmd_ready, 0);
              chk("rsp_early", rsp_valid, 0);
            end else begin
              chk("rsp_valid", rsp_valid, 1);
              chk("rsp_op", rsp_op, e.op);
              chk("rsp_count", rsp_count, e.cnt);
              chk("rsp_match", rsp_match, e.match);
              chk("rsp_err", rsp_err, e.err);
              chk("resp_buttons", {28'd0, btn_w}, 0);
              last = {e.op, e.cnt, e.match, e.err};
              void'(sb.pop_front());
            end
          end else begin
            chk("idle_buttons", {28'd0, btn_w}, 0);
            chk("idle_mode", mode, 0);
            chk("idle_ready", cmd_ready, 1);
            chk("idle_rsp", rsp_valid, 0);
            chk("rsp_hold", {rsp_op, rsp_count, rsp_match, rsp_err}, last);
          end
        end
      end
    join_none

    repeat (3) @(posedge clock);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single vote for candidate 2, then confirm its tally.
    do_cmd(1'b0, 2'd2, 1'b0);
    wait_idle();
    do_cmd(1'b1, 2'd2, 1'b0);
    wait_idle();

    // Three votes for candidate 0, read 0 and 1.
    repeat (3) begin
      do_cmd(1'b0, 2'd0, 1'b0);
      wait_idle();
    end
    do_cmd(1'b1, 2'd0, 1'b0);
    wait_idle();
    do_cmd(1'b1, 2'd1, 1'b0);
    wait_idle();

    // cmd_valid held across two back-to-back commands.
    do_cmd(1'b0, 2'd1, 1'b1);
    do_cmd(1'b1, 2'd1, 1'b0);
    wait_idle();

    // Reset in the middle of a PRESS aborts the vote.
    do_cmd(1'b0, 2'd1, 1'b0);
    repeat (5) @(posedge clock);
    apply_reset(1);
    do_cmd(1'b1, 2'd1, 1'b0);
    wait_idle();
    do_cmd(1'b1, 2'd2, 1'b0);
    wait_idle();

    // Vote while the machine never flashes.
    tie0 = 1'b1;
    do_cmd(1'b0, 2'd0, 1'b0);
    wait_idle();
    tie0 = 1'b0;
    do_cmd(1'b0, 2'd0, 1'b0);
    wait_idle();
    do_cmd(1'b1, 2'd0, 1'b0);
    wait_idle();

    // 256 votes for candidate 3 wrap both counts to 0.
    repeat (256) begin
      do_cmd(1'b0, 2'd3, 1'b0);
      wait_idle();
    end
    do_cmd(1'b1, 2'd3, 1'b0);
    wait_idle();

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
